aes128_inv_cipher: RTL and testbench

- Iterative AES-128 decryption core (FIPS-197 inverse cipher). It is the receive-side counterpart of the encryption datapath built from addroundkey-style stages.
- Takes a 128-bit ciphertext on a start pulse and processes one inverse round per clock.
- Fetches round keys from an external key-schedule store by index, and returns the plaintext with a one-cycle ready pulse.
- Sits between the AXI register/DMA front-end and the shared round-key RAM.

---
 rtl/aes_pkg.sv | 92 +++++++++
 rtl/aes_inv_sbox.sv | 35 +++
 rtl/aes128_inv_cipher.sv | 116 +++++++++++
 tb/tb_aes128_inv_cipher.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  aes_pkg
//  Shared types, constants and GF(2^8) helpers for the AES-128 inverse cipher.
//  Revision: 1.0
// ============================================================================
package aes_pkg;

    localparam int NR       = 10;
    localparam int RK_IDX_W = 4;

    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul_9(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gmul_b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gmul_d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gmul_e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // Byte idx = 4*col + row, byte 0 in the most significant position.
    function automatic logic [7:0] get_byte(input state_t s, input int idx);
        return s[127-8*idx -: 8];
    endfunction

    function automatic state_t inv_shift_rows(input state_t s);
        state_t r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = get_byte(s, 4*((c - row + 4) % 4) + row);
            end
        end
        return r;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t     r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = get_byte(s, 4*c);
            a1 = get_byte(s, 4*c+1);
            a2 = get_byte(s, 4*c+2);
            a3 = get_byte(s, 4*c+3);
            r[127-32*c -: 32] = {
                gmul_e(a0) ^ gmul_b(a1) ^ gmul_d(a2) ^ gmul_9(a3),
                gmul_9(a0) ^ gmul_e(a1) ^ gmul_b(a2) ^ gmul_d(a3),
                gmul_d(a0) ^ gmul_9(a1) ^ gmul_e(a2) ^ gmul_b(a3),
                gmul_b(a0) ^ gmul_d(a1) ^ gmul_9(a2) ^ gmul_e(a3)
            };
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_sbox.sv
`default_nettype none
// ============================================================================
//  aes_inv_sbox
//  Combinational AES inverse S-box (one byte).
//  Revision: 1.0
// ============================================================================
module aes_inv_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    // Entry for input x lives at bits [8*(255-x) +: 8].
    localparam logic [2047:0] C_INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign y_o = C_INV_SBOX[{~a_i, 3'b000} +: 8];

endmodule
`default_nettype wire

// File: rtl/aes128_inv_cipher.sv
`default_nettype none
// ============================================================================
//  aes128_inv_cipher
//  Iterative AES-128 decryption core: one inverse round per clock, round keys
//  fetched combinationally from an external key store by index.
//  Revision: 1.0
// ============================================================================
module aes128_inv_cipher #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [127:0] data_i,
    output logic [3:0]   rk_idx_o,
    input  logic [127:0] rk_i,
    output logic         busy_o,
    output logic [127:0] data_o,
    output logic         ready_o
);

    import aes_pkg::*;

    fsm_e                fsm_q, fsm_d;
    logic [RK_IDX_W-1:0] rnd_q, rnd_d;
    state_t              state_q, state_d;
    state_t              data_q, data_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic [RK_IDX_W-1:0] w_rk_idx;

    state_t w_shifted;
    state_t w_sub;
    state_t w_keyed;
    state_t w_mixed;

    assign w_shifted = inv_shift_rows(state_q);

    generate
        for (genvar i = 0; i < 16; i++) begin : g_sbox
            aes_inv_sbox u_inv_sbox (
                .a_i (w_shifted[8*i +: 8]),
                .y_o (w_sub[8*i +: 8])
            );
        end
    endgenerate

    // Shared by ROUND (then mixed) and FINAL (taken as plaintext directly).
    assign w_keyed = w_sub ^ rk_i;
    assign w_mixed = inv_mix_columns(w_keyed);

    always_comb begin
        fsm_d    = fsm_q;
        rnd_d    = rnd_q;
        state_d  = state_q;
        data_d   = data_q;
        busy_d   = busy_q;
        ready_d  = 1'b0;
        w_rk_idx = RK_IDX_W'(NR);
        case (fsm_q)
            ST_IDLE: begin
                w_rk_idx = RK_IDX_W'(NR);
                if (start_i) begin
                    state_d = data_i ^ rk_i;
                    rnd_d   = RK_IDX_W'(NR - 1);
                    busy_d  = 1'b1;
                    fsm_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                w_rk_idx = rnd_q;
                state_d  = w_mixed;
                rnd_d    = rnd_q - 1'b1;
                if (rnd_q == RK_IDX_W'(1)) begin
                    fsm_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                w_rk_idx = '0;
                data_d   = w_keyed;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
                fsm_d    = ST_IDLE;
            end
            default: begin
                fsm_d  = ST_IDLE;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            rnd_q   <= '0;
            state_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign rk_idx_o = w_rk_idx;
    assign busy_o   = busy_q;
    assign data_o   = data_q;
    assign ready_o  = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_aes128_inv_cipher.sv
`default_nettype none
// ============================================================================
//  tb_aes128_inv_cipher
//  Scoreboard bench for the AES-128 inverse cipher using FIPS-197 vectors.
//  Revision: 1.0
// ============================================================================
module tb_aes128_inv_cipher;

    localparam logic [127:0] C_KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [79:0]  C_RCON   = 80'h01020408102040801b36;

    localparam logic [2047:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [127:0] data_i;
    logic [3:0]   rk_idx_o;
    logic [127:0] rk_i;
    logic         busy_o;
    logic [127:0] data_o;
    logic         ready_o;

    logic [127:0] ks [0:10];
    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;

    typedef struct {
        logic [127:0] pt;
        int           at;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb rk_i = (rk_idx_o <= 4'd10) ? ks[rk_idx_o] : '0;

    aes128_inv_cipher #(.NR(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .data_i   (data_i),
        .rk_idx_o (rk_idx_o),
        .rk_i     (rk_i),
        .busy_o   (busy_o),
        .data_o   (data_o),
        .ready_o  (ready_o)
    );

    function automatic logic [7:0] sb8(input logic [7:0] x);
        return C_SBOX[{~x, 3'b000} +: 8];
    endfunction

    // Forward key expansion fills the external key store.
    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb8(t[31:24]), sb8(t[23:16]), sb8(t[15:8]), sb8(t[7:0])}
                    ^ {C_RCON[79-8*(i/4-1) -: 8], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && ready_o) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ready: ready_o=1 at cycle %0d, expected 0", cyc);
            end else begin
                e = sb.pop_front();
                chk("plaintext", data_o, e.pt);
                chk("ready_cycle", 128'(cyc), 128'(e.at));
            end
        end
    end

    initial begin
        int s;
        rst     = 1'b1;
        start_i = 1'b0;
        data_i  = '0;
        load_key(C_KEY_C1);
        tick();
        tick();
        chk("reset_busy",   128'(busy_o),   128'(0));
        chk("reset_ready",  128'(ready_o),  128'(0));
        chk("reset_data",   data_o,         128'(0));
        chk("reset_rk_idx", 128'(rk_idx_o), 128'(10));
        rst = 1'b0;
        tick();

        // C.1 block with a second start at cycle 5 that must be ignored
        s       = cyc;
        data_i  = C_CT_C1;
        start_i = 1'b1;
        sb.push_back('{C_PT_C1, s + 11});
        tick();
        start_i = 1'b0;
        data_i  = '0;
        repeat (4) tick();
        chk("busy_mid", 128'(busy_o), 128'(1));
        data_i  = C_CT_B;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        data_i  = '0;
        while (cyc < s + 11) tick();

        // Appendix B block issued in the ready cycle of the C.1 block
        load_key(C_KEY_B);
        data_i  = C_CT_B;
        start_i = 1'b1;
        sb.push_back('{C_PT_B, cyc + 11});
        chk("rk_idx_seq", 128'(rk_idx_o), 128'(10));
        tick();
        start_i = 1'b0;
        data_i  = '0;
        for (int k = 1; k <= 10; k++) begin
            chk("rk_idx_seq", 128'(rk_idx_o), 128'(10 - k));
            chk("b2b_hold", data_o, C_PT_C1);
            tick();
        end
        tick();

        // Reset in cycle 6 of a decryption discards the block
        data_i  = C_CT_B;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        data_i  = '0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy",   128'(busy_o),   128'(0));
        chk("rst_ready",  128'(ready_o),  128'(0));
        chk("rst_data",   data_o,         128'(0));
        chk("rst_rk_idx", 128'(rk_idx_o), 128'(10));
        repeat (15) tick();
        chk("rst_pending", 128'(sb.size()), 128'(0));

        s       = cyc;
        data_i  = C_CT_B;
        start_i = 1'b1;
        sb.push_back('{C_PT_B, s + 11});
        tick();
        start_i = 1'b0;
        data_i  = '0;
        repeat (11) tick();

        for (int k = 0; k < 50; k++) begin
            chk("idle_data", data_o, C_PT_B);
            chk("idle_ctrl", 128'({ready_o, busy_o, rk_idx_o}), 128'({1'b0, 1'b0, 4'd10}));
            tick();
        end
        chk("sb_drain", 128'(sb.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
